// File: rtl/free_running_counter.sv
// Free-running binary up-counter used as a heartbeat / cycle timestamp.
// Counts once per rising CLK edge, wraps modulo 2^WIDTH, and returns
// asynchronously to INIT while RSTN is low.
module free_running_counter #(
  parameter int unsigned      WIDTH = 31,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  output logic [WIDTH-1:0] data
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  // The initialiser sets the power-up value, so data reads INIT from time 0
  // even if RSTN is never pulsed.
  logic [WIDTH-1:0] count_q = INIT;
  logic [WIDTH-1:0] count_d;

  // Next count: WIDTH-bit increment, carry-out dropped, so all-ones wraps to zero.
  always_comb begin
    count_d = count_q + One;
  end

  // Count register: asynchronous return to INIT, otherwise advance every edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign data = count_q;

endmodule

// File: tb/tb_free_running_counter.sv
// Directed bench for free_running_counter: power-up value, counting, async
// reset mid-count, reset release on a clock edge, and wrap-around at two widths.
`timescale 1ns / 100ps
module tb_free_running_counter;

  localparam logic [30:0] WideInit = 31'h7FFF_FFFE;

  logic        clk;
  logic        rstn;
  logic        rstn_hi;
  logic [30:0] data_main;
  logic [3:0]  data_narrow;
  logic [30:0] data_wide;

  int unsigned n_vec;
  int unsigned n_err;

  free_running_counter u_main (
    .CLK  (clk),
    .RSTN (rstn),
    .data (data_main)
  );

  free_running_counter #(
    .WIDTH (4)
  ) u_narrow (
    .CLK  (clk),
    .RSTN (rstn_hi),
    .data (data_narrow)
  );

  free_running_counter #(
    .WIDTH (31),
    .INIT  (WideInit)
  ) u_wide (
    .CLK  (clk),
    .RSTN (rstn_hi),
    .data (data_wide)
  );

  // 2-unit period: rising edges at t = 1, 3, 5, ...; falling edges at t = 2k.
  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rstn    = 1'b1;
    rstn_hi = 1'b1;

    // Power-up value before the first rising edge.
    #0.5;
    check("powerup_main", 64'(data_main), 64'd0);
    check("powerup_narrow", 64'(data_narrow), 64'd0);
    check("powerup_wide", 64'(data_wide), 64'h7FFF_FFFE);

    // Free counting: after k edges the main counter reads k; the 4-bit one
    // wraps at 16 and the preloaded 31-bit one wraps after two edges.
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      check("count_main", 64'(data_main), 64'(k));
      check("no_x_main", 64'($isunknown(data_main)), 64'd0);
      if (k >= 14 && k <= 18) begin
        check("wrap_narrow", 64'(data_narrow), 64'(k % 16));
      end
      if (k <= 4) begin
        check("wrap_wide", 64'(data_wide), (64'h7FFF_FFFE + 64'(k)) & 64'h7FFF_FFFF);
      end
    end

    // Reset asserted between edges clears the count immediately.
    #0.5 rstn = 1'b0;
    #0.1;
    check("async_rst_clear", 64'(data_main), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_hold", 64'(data_main), 64'd0);

    // Release exactly at a rising edge: the register samples RSTN low on that
    // edge (nonblocking drive lands after it), so that edge must not count.
    @(posedge clk);
    rstn <= 1'b1;
    #0.5;
    check("edge_release_no_count", 64'(data_main), 64'd0);
    @(negedge clk);
    check("edge_release_hold", 64'(data_main), 64'd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("recount_main", 64'(data_main), 64'(k));
    end

    // At data == 17, drop reset mid-cycle with no clock edge in between.
    #0.5 rstn = 1'b0;
    #0.1;
    check("async_rst_at_17", 64'(data_main), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_3cyc", 64'(data_main), 64'd0);
    end

    // Release between edges: the very next rising edge counts.
    rstn = 1'b1;
    @(negedge clk);
    check("release_first", 64'(data_main), 64'd1);
    @(negedge clk);
    check("release_second", 64'(data_main), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
